wb_regfile: RTL

//   Writeback-stage consumer of the MEM/WB pipeline register, plus the architectural register file.
//   - Selects the write address (rt/rd) and the write data (ALU/memory).
//   - Commits the selected data into a 32x32 register file.
//   - Serves the two ID-stage read ports, with same-cycle write-through bypass.
//   - Exports the current WB target for the EX forwarding unit.
//   - Counts committed writes for debug and performance visibility.

---
 rtl/wb_regfile.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Writeback stage plus architectural register file. Selects the
//             writeback address (rt/rd) and data (ALU/memory), commits it to
//             the register file, and serves two combinational read ports
//             with same-cycle write-through bypass. The current writeback
//             target is exported for the EX forwarding unit, and committed
//             writes are counted.
//  Ports    : clk, reset (async, active-low)
//             wb_write_en, wb_addr_sel, wb_data_sel, wb_addr1, wb_addr2,
//             ALU_result, mem_data             - MEM/WB pipeline inputs
//             rd_addr_a/b -> rd_data_a/b       - ID-stage read ports
//             fwd_valid, fwd_addr, fwd_data    - WB forwarding outputs
//             commit_cnt                       - committed-write counter
//  Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_write_en,
  input  logic              wb_addr_sel,
  input  logic              wb_data_sel,
  input  logic [ADDR_W-1:0] wb_addr1,
  input  logic [ADDR_W-1:0] wb_addr2,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  commit_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              commit;
  logic [DATA_W-1:0] regs [NUM_REGS];

  // Selects collapse any non-1 value to the 0 choice, so an X/Z select
  // never propagates into the datapath.
  always_comb begin
    waddr = (wb_addr_sel === 1'b1) ? wb_addr2 : wb_addr1;
    wdata = (wb_data_sel === 1'b1) ? mem_data : ALU_result;
  end

  // Reset participates combinationally so an asserted reset immediately
  // kills the bypass, the forward-valid and any write in that cycle.
  assign commit = reset & wb_write_en & (waddr != '0);

  // Register 0 has no storage; it is a constant zero.
  assign regs[0] = '0;

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          regs[i] <= '0;
        end else if (commit && (waddr == ADDR_W'(i))) begin
          regs[i] <= wdata;
        end
      end
    end
  endgenerate

  // Read ports: index 0 is never bypassed; otherwise a same-cycle commit to
  // the addressed register is returned ahead of storage.
  always_comb begin
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (commit && (rd_addr_a == waddr)) begin
      rd_data_a = wdata;
    end else begin
      rd_data_a = regs[rd_addr_a];
    end

    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (commit && (rd_addr_b == waddr)) begin
      rd_data_b = wdata;
    end else begin
      rd_data_b = regs[rd_addr_b];
    end
  end

  // Address and data forward unmasked; consumers qualify with fwd_valid.
  assign fwd_valid = commit;
  assign fwd_addr  = waddr;
  assign fwd_data  = wdata;

  // Free-running modulo-2**CNT_W count of committed writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_cnt <= '0;
    end else if (commit) begin
      commit_cnt <= commit_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
